// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection for jal / jr / beq / fall-through,
// link register, and an optional circular return-address stack enabled by PC_SEQ_RAS_EN.
module pc_sequencer #(
    parameter int              PC_W      = 16,
    parameter int              JOFF_W    = 9,
    parameter int              BOFF_W    = 6,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_write,
    input  logic [15:0]                  instruction,
    input  logic                         zero_flag,
    input  logic                         branch,
    input  logic                         jal,
    input  logic                         jr,
    input  logic [PC_W-1:0]              jr_target,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              next_pc,
    output logic [PC_W-1:0]              link_address,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [PC_W-1:0] pc_plus_one;
    logic [PC_W-1:0] jal_offset;
    logic [PC_W-1:0] beq_offset;
    logic [PC_W-1:0] return_target;
    logic            unused_bits;

    // Offsets are sign-extended through a signed cast so any PC_W >= offset width works.
    assign jal_offset  = PC_W'($signed(instruction[JOFF_W-1:0]));
    assign beq_offset  = PC_W'($signed(instruction[BOFF_W-1:0]));
    assign pc_plus_one = pc + PC_W'(1);
    assign unused_bits = ^instruction;

    always_comb begin
        next_pc = pc_plus_one;
        if (jal) begin
            next_pc = pc + jal_offset;
        end else if (jr) begin
            next_pc = return_target;
        end else if (branch && zero_flag) begin
            next_pc = pc + beq_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            link_address <= '0;
        end else if (pc_write) begin
            pc <= next_pc;
            if (jal) begin
                link_address <= pc_plus_one;
            end
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_sp;
    logic [PC_W-1:0]  ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             do_push;
    logic             do_pop;

    // ras_sp is the next free slot; once full it also addresses the oldest entry,
    // so a push simply overwrites it and the ring keeps the newest RAS_DEPTH addresses.
    assign ras_top       = ras_mem[ras_sp - PTR_W'(1)];
    assign ras_empty     = (ras_count == '0);
    assign ras_full      = (ras_count == CNT_W'(RAS_DEPTH));
    assign return_target = ras_empty ? jr_target : ras_top;
    assign do_push       = pc_write && jal;
    assign do_pop        = pc_write && !jal && jr;

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            ras_mem[ras_sp] <= pc_plus_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_sp        <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (do_push) begin
            ras_sp <= ras_sp + PTR_W'(1);
            if (ras_full) begin
                ras_overflow <= 1'b1;
            end else begin
                ras_count <= ras_count + CNT_W'(1);
            end
        end else if (do_pop) begin
            if (ras_empty) begin
                ras_underflow <= 1'b1;
            end else begin
                ras_sp    <= ras_sp - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end
`else
    assign return_target = jr_target;
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized commits
// compared against a queue-based reference model (follows PC_SEQ_RAS_EN if defined).
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic [15:0] instruction;
    logic        zero_flag;
    logic        branch;
    logic        jal;
    logic        jr;
    logic [15:0] jr_target;
    logic [15:0] pc;
    logic [15:0] next_pc;
    logic [15:0] link_address;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_pc;
    int m_link;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W(16), .JOFF_W(9), .BOFF_W(6), .RESET_PC(16'h0010), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .instruction(instruction),
        .zero_flag(zero_flag), .branch(branch), .jal(jal), .jr(jr),
        .jr_target(jr_target), .pc(pc), .next_pc(next_pc),
        .link_address(link_address), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sext(input int value, input int width);
        int v;
        v = value & ((1 << width) - 1);
        if (v >= (1 << (width - 1))) v = v - (1 << width);
        return v;
    endfunction

    // Reference next PC from the rules: priority jal, jr, taken branch, increment.
    function automatic int model_next();
        int target;
        if (jal)                      target = m_pc + sext(int'(instruction), 9);
        else if (jr) begin
            if (RAS_ON && m_stack.size() > 0) target = m_stack[$];
            else                              target = int'(jr_target);
        end
        else if (branch && zero_flag) target = m_pc + sext(int'(instruction), 6);
        else                          target = m_pc + 1;
        return target & 16'hFFFF;
    endfunction

    task automatic model_commit(input int target);
        if (jal) begin
            m_link = (m_pc + 1) & 16'hFFFF;
            if (RAS_ON) begin
                m_stack.push_back(m_link);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
            end
        end else if (jr && RAS_ON) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else                    m_unf = 1'b1;
        end
        m_pc = target;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".pc"},   {16'h0, pc},           m_pc);
        checkOutput({tag, ".link"}, {16'h0, link_address}, m_link);
        checkOutput({tag, ".cnt"},  {29'h0, ras_count},    m_stack.size());
        checkOutput({tag, ".ovf"},  {31'h0, ras_overflow}, {31'h0, m_ovf});
        checkOutput({tag, ".unf"},  {31'h0, ras_underflow},{31'h0, m_unf});
    endtask

    task automatic applyStimulus(input logic pw, input logic [15:0] instr, input logic z,
                                 input logic br, input logic j, input logic r,
                                 input logic [15:0] tgt);
        int expected;
        @(negedge clk);
        rst = 1'b0; pc_write = pw; instruction = instr; zero_flag = z;
        branch = br; jal = j; jr = r; jr_target = tgt;
        #1;
        expected = model_next();
        checkOutput("next_pc", {16'h0, next_pc}, expected);
        @(posedge clk);
        if (pw) model_commit(expected);
        #1;
        checkState("step");
    endtask

    // Reset is driven with pc_write and jal high to confirm it overrides a commit.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; pc_write = 1'b1; jal = 1'b1; jr = 1'b0; branch = 1'b0;
        instruction = 16'h0005; zero_flag = 1'b0; jr_target = 16'h0000;
        @(posedge clk);
        m_pc = 16'h0010; m_link = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        checkState("reset");
        rst = 1'b0; pc_write = 1'b0; jal = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pc_write = 1'b0; instruction = '0; zero_flag = 1'b0;
        branch = 1'b0; jal = 1'b0; jr = 1'b0; jr_target = '0;
        m_pc = 0; m_link = 0; m_ovf = 1'b0; m_unf = 1'b0;

        doReset();
        checkOutput("rst_pc", {16'h0, pc}, 32'h0010);
        checkOutput("rst_link", {16'h0, link_address}, 32'h0);

        // Branch taken / not taken from pc 0x20
        applyStimulus(1, 16'h0010, 0, 0, 1, 0, 16'h0);
        checkOutput("jal_to_20", {16'h0, pc}, 32'h0020);
        applyStimulus(1, 16'h003E, 1, 1, 0, 0, 16'h0);
        checkOutput("beq_taken", {16'h0, pc}, 32'h001E);
        doReset();
        applyStimulus(1, 16'h0010, 0, 0, 1, 0, 16'h0);
        applyStimulus(1, 16'h003E, 0, 1, 0, 0, 16'h0);
        checkOutput("beq_not_taken", {16'h0, pc}, 32'h0021);

        // Wrap at the top of the address space and a negative jal offset
        doReset();
        applyStimulus(1, 16'h0000, 0, 0, 0, 1, 16'hFFFF);
        applyStimulus(1, 16'h0000, 0, 0, 0, 0, 16'h0000);
        checkOutput("wrap_pc", {16'h0, pc}, 32'h0000);
        doReset();
        applyStimulus(1, 16'h0000, 0, 0, 0, 1, 16'h0005);
        applyStimulus(1, 16'h01FB, 0, 0, 1, 0, 16'h0000);
        checkOutput("jal_neg_pc", {16'h0, pc}, 32'h0000);
        checkOutput("jal_neg_link", {16'h0, link_address}, 32'h0006);

        // Held commits: nothing moves, next_pc still follows jal
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 16'h0007, 0, 0, 1, 0, 16'h0000);
            checkOutput("hold_next", {16'h0, next_pc}, 32'h0007);
        end
        checkOutput("hold_pc", {16'h0, pc}, 32'h0000);

        // jal and jr together: jal wins
        applyStimulus(1, 16'h0003, 1, 1, 1, 1, 16'h4444);
        checkOutput("jal_over_jr", {16'h0, pc}, 32'h0003);

        // Five calls from 0x10..0x50, then five returns
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h0010, 0, 0, 1, 0, 16'h0);
`ifdef PC_SEQ_RAS_EN
        checkOutput("ras_full_cnt", {29'h0, ras_count}, 32'd4);
        checkOutput("ras_ovf", {31'h0, ras_overflow}, 32'd1);
`endif
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h0000, 0, 0, 0, 1, 16'h0AAA);
`ifdef PC_SEQ_RAS_EN
        checkOutput("ras_last_pc", {16'h0, pc}, 32'h0AAA);
        checkOutput("ras_unf", {31'h0, ras_underflow}, 32'd1);
`else
        checkOutput("jr_plain_pc", {16'h0, pc}, 32'h0AAA);
        checkOutput("no_ras_cnt", {29'h0, ras_count}, 32'd0);
`endif

        // Randomized commits, holds and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, 16'($urandom),
                              1'($urandom), $urandom_range(0, 2) == 0,
                              $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                              16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
